// File: rtl/vga_board_commit_ctrl_if.sv
// Tile write port between the game FSM (master) and the board commit controller (slave).
interface vga_board_commit_ctrl_if #(
  parameter int unsigned IDX_W  = 4,
  parameter int unsigned TILE_W = 16
);
  logic              tile_valid;
  logic              tile_ready;
  logic [IDX_W-1:0]  tile_idx;
  logic [TILE_W-1:0] tile_val;
  logic              tile_last;

  modport master (
    output tile_valid,
    output tile_idx,
    output tile_val,
    output tile_last,
    input  tile_ready
  );

  modport slave (
    input  tile_valid,
    input  tile_idx,
    input  tile_val,
    input  tile_last,
    output tile_ready
  );
endinterface

// File: rtl/vga_board_commit_ctrl.sv
// Collects tile writes into a shadow board and commits them to the renderer's
// board_state only at the start of a frame (vsync falling edge) to avoid tearing.
module vga_board_commit_ctrl #(
  parameter int unsigned NTILES  = 16,
  parameter int unsigned TILE_W  = 16,
  parameter int unsigned MAX_VAL = 10,
  parameter int unsigned FCNT_W  = 8
) (
  input  logic                     dclk,
  input  logic                     clr_n,
  input  logic                     vsync,
  input  logic                     clear,
  vga_board_commit_ctrl_if.slave   tile,
  output logic [NTILES*TILE_W-1:0] board_state,
  output logic                     commit_pend,
  output logic                     commit_done,
  output logic                     bad_val,
  output logic [FCNT_W-1:0]        frame_cnt
);

  localparam int unsigned IDX_W   = $clog2(NTILES);
  localparam int unsigned BOARD_W = NTILES * TILE_W;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [0:0]                    state, state_nxt;
  logic [NTILES-1:0][TILE_W-1:0] shadow, shadow_nxt;
  logic [BOARD_W-1:0]            board_nxt;
  logic                          done_nxt;
  logic                          bad_nxt;
  logic                          vsync_d;

  logic                          fall_c;
  logic                          accept_c;
  logic                          out_of_range_c;
  logic [IDX_W-1:0]              idx_c;
  logic [TILE_W-1:0]             wr_val_c;

  // Frame boundary and write qualification
  always_comb begin
    fall_c         = vsync_d & ~vsync;
    accept_c       = tile.tile_valid & tile.tile_ready;
    idx_c          = tile.tile_idx;
    out_of_range_c = tile.tile_val > TILE_W'(MAX_VAL);
    wr_val_c       = out_of_range_c ? '0 : tile.tile_val;
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt  = state;
    shadow_nxt = shadow;
    board_nxt  = board_state;
    done_nxt   = 1'b0;
    bad_nxt    = bad_val;
    case (state)
      IDLE: begin
        // clear wipes the board first so a same-cycle write survives
        if (clear) begin
          shadow_nxt = '0;
        end
        if (accept_c) begin
          shadow_nxt[idx_c] = wr_val_c;
          if (out_of_range_c) begin
            bad_nxt = 1'b1;
          end
          if (tile.tile_last) begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (fall_c) begin
          board_nxt = BOARD_W'(shadow);
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) begin
      shadow          <= '0;
      board_state     <= '0;
      commit_done     <= 1'b0;
      commit_pend     <= 1'b0;
      bad_val         <= 1'b0;
      vsync_d         <= 1'b1;
      frame_cnt       <= '0;
      tile.tile_ready <= 1'b1;
    end else begin
      shadow          <= shadow_nxt;
      board_state     <= board_nxt;
      commit_done     <= done_nxt;
      commit_pend     <= (state_nxt == WAIT);
      bad_val         <= bad_nxt;
      vsync_d         <= vsync;
      tile.tile_ready <= (state_nxt == IDLE);
      if (fall_c) begin
        frame_cnt <= frame_cnt + FCNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_vga_board_commit_ctrl.sv
// Directed bench for vga_board_commit_ctrl with a frame-level reference model.
module tb_vga_board_commit_ctrl;

  logic dclk  = 1'b0;
  logic clr_n = 1'b1;
  logic vsync = 1'b1;
  logic clear = 1'b0;

  logic [255:0] board_state;
  logic         commit_pend;
  logic         commit_done;
  logic         bad_val;
  logic [7:0]   frame_cnt;

  vga_board_commit_ctrl_if #(.IDX_W(4), .TILE_W(16)) tif ();

  vga_board_commit_ctrl dut (
    .dclk        (dclk),
    .clr_n       (clr_n),
    .vsync       (vsync),
    .clear       (clear),
    .tile        (tif),
    .board_state (board_state),
    .commit_pend (commit_pend),
    .commit_done (commit_done),
    .bad_val     (bad_val),
    .frame_cnt   (frame_cnt)
  );

  always #5 dclk = ~dclk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a shadow board, a displayed board and a pending flag
  logic [15:0] m_shadow [16];
  logic [15:0] m_board  [16];
  logic        m_pend, m_done, m_bad, m_vs_d, m_fall;
  logic [7:0]  m_fcnt;

  always @(posedge dclk or negedge clr_n) begin
    if (!clr_n) begin
      for (int i = 0; i < 16; i++) begin
        m_shadow[i] = 16'd0;
        m_board[i]  = 16'd0;
      end
      m_pend = 1'b0;
      m_done = 1'b0;
      m_bad  = 1'b0;
      m_vs_d = 1'b1;
      m_fcnt = 8'd0;
    end else begin
      m_fall = m_vs_d && !vsync;
      m_done = 1'b0;
      if (m_pend) begin
        if (m_fall) begin
          for (int i = 0; i < 16; i++) m_board[i] = m_shadow[i];
          m_done = 1'b1;
          m_pend = 1'b0;
        end
      end else begin
        if (clear) begin
          for (int i = 0; i < 16; i++) m_shadow[i] = 16'd0;
        end
        if (tif.tile_valid) begin
          if (tif.tile_val > 16'd10) begin
            m_shadow[tif.tile_idx] = 16'd0;
            m_bad = 1'b1;
          end else begin
            m_shadow[tif.tile_idx] = tif.tile_val;
          end
          if (tif.tile_last) m_pend = 1'b1;
        end
      end
      if (m_fall) m_fcnt = m_fcnt + 8'd1;
      m_vs_d = vsync;
    end
  end

  function automatic logic [255:0] model_board();
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) v[i*16 +: 16] = m_board[i];
    return v;
  endfunction

  // Cycle-by-cycle comparison on the inactive edge
  always @(negedge dclk) begin
    chk("board",  board_state,            model_board());
    chk("pend",   256'(commit_pend),      256'(m_pend));
    chk("done",   256'(commit_done),      256'(m_done));
    chk("badval", 256'(bad_val),          256'(m_bad));
    chk("fcnt",   256'(frame_cnt),        256'(m_fcnt));
    chk("ready",  256'(tif.tile_ready),   256'(!m_pend));
  end

  task automatic tick();
    @(posedge dclk);
    #2;
  endtask

  task automatic wr(input logic [3:0] idx, input logic [15:0] val, input logic last);
    tif.tile_valid = 1'b1;
    tif.tile_idx   = idx;
    tif.tile_val   = val;
    tif.tile_last  = last;
    tick();
    tif.tile_valid = 1'b0;
    tif.tile_last  = 1'b0;
  endtask

  task automatic frame();
    vsync = 1'b0;
    tick();
    vsync = 1'b1;
    tick();
  endtask

  logic [255:0] exp_b;

  initial begin
    tif.tile_valid = 1'b0;
    tif.tile_idx   = 4'd0;
    tif.tile_val   = 16'd0;
    tif.tile_last  = 1'b0;
    #1 clr_n = 1'b0;
    repeat (3) tick();
    chk("rst_ready", 256'(tif.tile_ready), 256'(1'b1));
    chk("rst_board", board_state, 256'd0);
    clr_n = 1'b1;
    tick();
    chk("rst_fcnt", 256'(frame_cnt), 256'd0);
    chk("rst_pend", 256'(commit_pend), 256'd0);

    // Basic batch: commit lands only at the next vsync fall
    wr(4'd3, 16'd2, 1'b0);
    wr(4'd12, 16'd5, 1'b1);
    repeat (3) tick();
    chk("pre_fall_board", board_state, 256'd0);
    chk("pre_fall_pend", 256'(commit_pend), 256'd1);
    vsync = 1'b0;
    tick();
    chk("t2_idx3",  256'(board_state[48 +: 16]), 256'(16'd2));
    chk("t2_idx12", 256'(board_state[192 +: 16]), 256'(16'd5));
    chk("t2_done",  256'(commit_done), 256'd1);
    chk("t2_pend",  256'(commit_pend), 256'd0);
    chk("t2_fcnt",  256'(frame_cnt), 256'd1);
    vsync = 1'b1;
    tick();

    // Out-of-range value stores zero and latches bad_val
    wr(4'd0, 16'd7, 1'b1);
    frame();
    chk("t3_idx0_legal", 256'(board_state[0 +: 16]), 256'(16'd7));
    wr(4'd0, 16'd11, 1'b1);
    frame();
    chk("t3_idx0_zero", 256'(board_state[0 +: 16]), 256'd0);
    chk("t3_bad", 256'(bad_val), 256'd1);
    chk("t3_keep_idx3", 256'(board_state[48 +: 16]), 256'(16'd2));

    // Writes and clear during WAIT are ignored
    wr(4'd5, 16'd3, 1'b1);
    clear = 1'b1;
    wr(4'd5, 16'd9, 1'b0);
    chk("t4_ready_low", 256'(tif.tile_ready), 256'd0);
    wr(4'd6, 16'd4, 1'b1);
    clear = 1'b0;
    frame();
    chk("t4_idx5", 256'(board_state[80 +: 16]), 256'(16'd3));
    chk("t4_idx6", 256'(board_state[96 +: 16]), 256'd0);
    chk("t4_idx12", 256'(board_state[192 +: 16]), 256'(16'd5));

    // tile_last in the same cycle as a fall waits a whole frame
    vsync = 1'b0;
    wr(4'd7, 16'd1, 1'b1);
    vsync = 1'b1;
    tick();
    chk("t4_same_pend", 256'(commit_pend), 256'd1);
    chk("t4_same_idx7", 256'(board_state[112 +: 16]), 256'd0);
    frame();
    chk("t4_late_idx7", 256'(board_state[112 +: 16]), 256'(16'd1));
    chk("bad_sticky", 256'(bad_val), 256'd1);

    // clear alone, then clear combined with a write
    clear = 1'b1;
    tick();
    wr(4'd1, 16'd4, 1'b1);
    clear = 1'b0;
    frame();
    exp_b = '0;
    exp_b[16 +: 16] = 16'd4;
    chk("clear_board", board_state, exp_b);

    // Frame counter wrap with a commit pending across it
    for (int k = 0; k < 300 && m_fcnt != 8'd255; k++) frame();
    chk("pre_wrap_fcnt", 256'(frame_cnt), 256'(8'd255));
    wr(4'd9, 16'd6, 1'b1);
    frame();
    chk("wrap_fcnt", 256'(frame_cnt), 256'd0);
    exp_b[144 +: 16] = 16'd6;
    chk("wrap_board", board_state, exp_b);

    // Reset during WAIT drops the batch
    wr(4'd2, 16'd8, 1'b1);
    chk("t6_pend", 256'(commit_pend), 256'd1);
    #1 clr_n = 1'b0;
    #1;
    chk("t6_board", board_state, 256'd0);
    chk("t6_pend_clr", 256'(commit_pend), 256'd0);
    chk("t6_ready", 256'(tif.tile_ready), 256'd1);
    chk("t6_bad_clr", 256'(bad_val), 256'd0);
    tick();
    clr_n = 1'b1;
    tick();
    vsync = 1'b0;
    tick();
    chk("t6_no_done", 256'(commit_done), 256'd0);
    chk("t6_board_after", board_state, 256'd0);
    chk("t6_fcnt", 256'(frame_cnt), 256'd1);
    vsync = 1'b1;
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
